// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the ALU sharing arbiter and its users.
//   ALUOP_W      : width of an ALU opcode
//   ALU_*        : opcode encodings (passed through the arbiter unchanged)
//   arb_state_e  : arbiter FSM states
package alu_pkg;

  localparam int ALUOP_W = 5;

  localparam logic [ALUOP_W-1:0] ALU_AND  = 5'b00000;
  localparam logic [ALUOP_W-1:0] ALU_OR   = 5'b00001;
  localparam logic [ALUOP_W-1:0] ALU_ADD  = 5'b00010;
  localparam logic [ALUOP_W-1:0] ALU_SLT  = 5'b00011;
  localparam logic [ALUOP_W-1:0] ALU_XOR  = 5'b00100;
  localparam logic [ALUOP_W-1:0] ALU_SLTU = 5'b00101;
  localparam logic [ALUOP_W-1:0] ALU_SRL  = 5'b00110;
  localparam logic [ALUOP_W-1:0] ALU_SLL  = 5'b00111;
  localparam logic [ALUOP_W-1:0] ALU_SRA  = 5'b01000;
  localparam logic [ALUOP_W-1:0] ALU_SUB  = 5'b10010;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_EXEC = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: purely combinational round-robin pick.
//   req_i  : request vector
//   ptr_i  : highest-priority index this cycle (must be < NREQ)
//   gnt_o  : one-hot grant, zero when no request
//   idx_o  : index of the granted requester (0 when none)
//   any_o  : at least one request present
module rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic [2*NREQ-1:0] req_dbl_s;
  logic [NREQ-1:0]   req_rot_s;
  logic [IDX_W:0]    sum_s;
  logic              found_s;

  // Rotate the request vector so ptr_i sits at bit 0, take the lowest set
  // bit, then map the rotated position back to an absolute index mod NREQ.
  always_comb begin
    req_dbl_s = {req_i, req_i} >> ptr_i;
    req_rot_s = req_dbl_s[NREQ-1:0];
    sum_s     = '0;
    found_s   = 1'b0;
    idx_o     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found_s && req_rot_s[i]) begin
        found_s = 1'b1;
        sum_s   = {1'b0, ptr_i} + (IDX_W+1)'(i);
        if (sum_s >= (IDX_W+1)'(NREQ)) begin
          sum_s = sum_s - (IDX_W+1)'(NREQ);
        end else begin
          sum_s = sum_s;
        end
        idx_o = sum_s[IDX_W-1:0];
      end else begin
        found_s = found_s;
      end
    end
    any_o = found_s;
    gnt_o = found_s ? ({{(NREQ-1){1'b0}}, 1'b1} << idx_o) : '0;
  end

endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb: shares one combinational ALU between NREQ requesters.
//   clk_i, rst_i           : clock, synchronous active-high reset
//   req_valid_i/ready_o    : per-requester request handshake
//   req_aluop_i/a_i/b_i    : packed per-requester opcode and operands
//   rsp_valid_o/ready_i    : per-requester response handshake
//   rsp_result_o           : shared result, qualified by rsp_valid_o
//   alu_op_o/a_o/b_o       : registered operands towards the ALU
//   alu_result_i           : combinational ALU result
// One operation is in flight at a time: IDLE (accept) -> EXEC -> RESP.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NREQ-1:0]         req_valid_i,
  output logic [NREQ-1:0]         req_ready_o,
  input  logic [NREQ*ALUOP_W-1:0] req_aluop_i,
  input  logic [NREQ*WIDTH-1:0]   req_a_i,
  input  logic [NREQ*WIDTH-1:0]   req_b_i,
  output logic [NREQ-1:0]         rsp_valid_o,
  input  logic [NREQ-1:0]         rsp_ready_i,
  output logic [WIDTH-1:0]        rsp_result_o,
  output logic [ALUOP_W-1:0]      alu_op_o,
  output logic [WIDTH-1:0]        alu_a_o,
  output logic [WIDTH-1:0]        alu_b_o,
  input  logic [WIDTH-1:0]        alu_result_i
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);
  localparam logic [NREQ-1:0]  ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [ALUOP_W-1:0]  op_q, op_d;
  logic [WIDTH-1:0]    a_q, a_d;
  logic [WIDTH-1:0]    b_q, b_d;
  logic [WIDTH-1:0]    result_q, result_d;
  logic [NREQ-1:0]     rsp_valid_q, rsp_valid_d;

  logic [NREQ-1:0]     arb_gnt_s;
  logic [IDX_W-1:0]    arb_idx_s;
  logic                arb_any_s;
  logic [ALUOP_W-1:0]  sel_op_s;
  logic [WIDTH-1:0]    sel_a_s;
  logic [WIDTH-1:0]    sel_b_s;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req_i (req_valid_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt_s),
    .idx_o (arb_idx_s),
    .any_o (arb_any_s)
  );

  // Grant is only visible while idle; EXEC/RESP never accept a request.
  assign req_ready_o  = (state_q == ARB_IDLE) ? arb_gnt_s : '0;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_result_o = result_q;
  assign alu_op_o     = op_q;
  assign alu_a_o      = a_q;
  assign alu_b_o      = b_q;

  // AND-OR mux of the granted requester's opcode and operands.
  always_comb begin
    sel_op_s = '0;
    sel_a_s  = '0;
    sel_b_s  = '0;
    for (int k = 0; k < NREQ; k++) begin
      sel_op_s = sel_op_s | (req_aluop_i[k*ALUOP_W +: ALUOP_W] & {ALUOP_W{arb_gnt_s[k]}});
      sel_a_s  = sel_a_s  | (req_a_i[k*WIDTH +: WIDTH] & {WIDTH{arb_gnt_s[k]}});
      sel_b_s  = sel_b_s  | (req_b_i[k*WIDTH +: WIDTH] & {WIDTH{arb_gnt_s[k]}});
    end
  end

  // FSM next state plus latch/result/response updates.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;
    rsp_valid_d = rsp_valid_q;
    case (state_q)
      ARB_IDLE: begin
        // A grant is a handshake: ready equals the grant while idle.
        if (arb_any_s) begin
          op_d     = sel_op_s;
          a_d      = sel_a_s;
          b_d      = sel_b_s;
          grant_d  = arb_idx_s;
          rr_ptr_d = (arb_idx_s == LAST_IDX) ? '0 : (arb_idx_s + IDX_W'(1));
          state_d  = ARB_EXEC;
        end else begin
          state_d  = ARB_IDLE;
        end
      end
      ARB_EXEC: begin
        result_d    = alu_result_i;
        rsp_valid_d = ONE_HOT0 << grant_q;
        state_d     = ARB_RESP;
      end
      ARB_RESP: begin
        // Only the owner's ready bit can complete the response.
        if (|(rsp_ready_i & rsp_valid_q)) begin
          rsp_valid_d = '0;
          state_d     = ARB_IDLE;
        end else begin
          state_d     = ARB_RESP;
        end
      end
      default: begin
        rsp_valid_d = '0;
        state_d     = ARB_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset; reset drops any operation in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ARB_IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
module tb_alu_share_arb;
  import alu_pkg::*;

  localparam int NREQ  = 2;
  localparam int WIDTH = 32;

  logic                    clk;
  logic                    rst;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*ALUOP_W-1:0] req_aluop;
  logic [NREQ*WIDTH-1:0]   req_a;
  logic [NREQ*WIDTH-1:0]   req_b;
  logic [NREQ-1:0]         rsp_valid;
  logic [NREQ-1:0]         rsp_ready;
  logic [WIDTH-1:0]        rsp_result;
  logic [ALUOP_W-1:0]      alu_op;
  logic [WIDTH-1:0]        alu_a;
  logic [WIDTH-1:0]        alu_b;
  logic [WIDTH-1:0]        alu_result;

  int checks = 0;
  int errors = 0;
  logic [4:0] ops [10];

  alu_share_arb #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_aluop_i  (req_aluop),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_result_o (rsp_result),
    .alu_op_o     (alu_op),
    .alu_a_o      (alu_a),
    .alu_b_o      (alu_b),
    .alu_result_i (alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (op)
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_ADD:  r = a + b;
      ALU_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_XOR:  r = a ^ b;
      ALU_SLTU: r = (a < b) ? 32'd1 : 32'd0;
      ALU_SRL:  r = a >> b[4:0];
      ALU_SLL:  r = a << b[4:0];
      ALU_SRA:  r = $signed(a) >>> b[4:0];
      ALU_SUB:  r = a - b;
      default:  r = 32'd0;
    endcase
    return r;
  endfunction

  // The bench plays the external ALU.
  assign alu_result = ref_alu(alu_op, alu_a, alu_b);

  function automatic logic [31:0] a_of(input int n, input int k);
    return ((k == 1) ? 32'h8000_0000 : 32'h0000_0000) ^ 32'(n * 16 + 3);
  endfunction

  function automatic logic [31:0] b_of(input int n, input int k);
    return 32'(n + k + 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    req_aluop[k*5 +: 5] = op;
    req_a[k*32 +: 32]   = a;
    req_b[k*32 +: 32]   = b;
  endtask

  initial begin
    ops[0] = ALU_AND;  ops[1] = ALU_OR;   ops[2] = ALU_ADD; ops[3] = ALU_SLT;
    ops[4] = ALU_XOR;  ops[5] = ALU_SLTU; ops[6] = ALU_SRL; ops[7] = ALU_SLL;
    ops[8] = ALU_SRA;  ops[9] = ALU_SUB;

    rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
    req_aluop = '0; req_a = '0; req_b = '0;
    tick(); tick();
    rst = 1'b0; #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);

    // Single ADD from requester 0
    set_req(0, ALU_ADD, 32'd5, 32'd7); req_valid = 2'b01; rsp_ready = 2'b11; #1;
    chk("t1_ready", 32'(req_ready), 32'd1);
    tick(); req_valid = 2'b00; #1;
    chk("t1_exec_a", alu_a, 32'd5);
    chk("t1_exec_b", alu_b, 32'd7);
    chk("t1_exec_op", 32'(alu_op), 32'd2);
    chk("t1_exec_rsp", 32'(rsp_valid), 32'd0);
    chk("t1_exec_ready", 32'(req_ready), 32'd0);
    tick(); #1;
    chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t1_rsp_result", rsp_result, 32'd12);
    tick(); #1;
    chk("t1_idle_rsp", 32'(rsp_valid), 32'd0);
    chk("t1_hold_a", alu_a, 32'd5);

    // Two simultaneous requesters
    rst = 1'b1; tick(); rst = 1'b0; #1;
    set_req(0, ALU_SUB, 32'd10, 32'd3); set_req(1, ALU_OR, 32'h0000_00F0, 32'h0000_000F);
    req_valid = 2'b11; rsp_ready = 2'b11; #1;
    chk("t2_ready0", 32'(req_ready), 32'd1);
    tick(); #1;
    chk("t2_exec_op", 32'(alu_op), 32'h12);
    chk("t2_exec_ready", 32'(req_ready), 32'd0);
    tick(); #1;
    chk("t2_rsp0_valid", 32'(rsp_valid), 32'd1);
    chk("t2_rsp0_result", rsp_result, 32'd7);
    tick(); #1;
    chk("t2_ready1", 32'(req_ready), 32'd2);
    tick(); #1;
    chk("t2_exec_a", alu_a, 32'h0000_00F0);
    tick(); req_valid = 2'b00; #1;
    chk("t2_rsp1_valid", 32'(rsp_valid), 32'd2);
    chk("t2_rsp1_result", rsp_result, 32'h0000_00FF);
    tick(); #1;

    // Backpressure on requester 1's response
    set_req(1, ALU_XOR, 32'h0000_00AA, 32'h0000_00FF); req_valid = 2'b10; rsp_ready = 2'b00; #1;
    chk("t3_ready", 32'(req_ready), 32'd2);
    tick(); set_req(0, ALU_SLL, 32'd1, 32'd4); req_valid = 2'b01; #1;
    chk("t3_exec_ready", 32'(req_ready), 32'd0);
    tick(); rsp_ready = 2'b01; #1;
    for (int i = 0; i < 5; i++) begin
      chk("t3_bp_valid", 32'(rsp_valid), 32'd2);
      chk("t3_bp_result", rsp_result, 32'h0000_0055);
      chk("t3_bp_ready", 32'(req_ready), 32'd0);
      tick(); #1;
    end
    rsp_ready = 2'b10; #1;
    chk("t3_last_valid", 32'(rsp_valid), 32'd2);
    tick(); #1;

    // Reset during EXEC
    chk("t4_ready", 32'(req_ready), 32'd1);
    chk("t4_idle_rsp", 32'(rsp_valid), 32'd0);
    tick(); rst = 1'b1; req_valid = 2'b00; #1;
    chk("t4_exec_op", 32'(alu_op), 32'd7);
    chk("t4_exec_a", alu_a, 32'd1);
    chk("t4_exec_b", alu_b, 32'd4);
    tick(); rst = 1'b0; #1;
    chk("t4_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t4_rst_rsp_result", rsp_result, 32'd0);
    chk("t4_rst_alu_op", 32'(alu_op), 32'd0);
    chk("t4_rst_alu_a", alu_a, 32'd0);
    chk("t4_rst_alu_b", alu_b, 32'd0);
    chk("t4_rst_ready", 32'(req_ready), 32'd0);
    tick(); #1;
    chk("t4_no_rsp", 32'(rsp_valid), 32'd0);
    set_req(1, ALU_ADD, 32'd3, 32'd4); req_valid = 2'b10; rsp_ready = 2'b11; #1;
    chk("t4_next_ready", 32'(req_ready), 32'd2);
    tick(); req_valid = 2'b00; #1;
    tick(); #1;
    chk("t4_next_valid", 32'(rsp_valid), 32'd2);
    chk("t4_next_result", rsp_result, 32'd7);
    tick(); #1;

    // Sustained load, both requesters always valid
    rsp_ready = 2'b11;
    for (int n = 0; n < 20; n++) begin
      int k;
      logic [1:0] exp_gnt;
      k = n % 2;
      exp_gnt = (k == 0) ? 2'b01 : 2'b10;
      set_req(0, ops[n % 10], a_of(n, 0), b_of(n, 0));
      set_req(1, ops[n % 10], a_of(n, 1), b_of(n, 1));
      req_valid = 2'b11; #1;
      chk("t5_ready", 32'(req_ready), 32'(exp_gnt));
      chk("t5_onehot0", 32'($onehot0(req_ready)), 32'd1);
      tick(); #1;
      chk("t5_exec_ready", 32'(req_ready), 32'd0);
      tick(); #1;
      chk("t5_rsp_valid", 32'(rsp_valid), 32'(exp_gnt));
      chk("t5_result", rsp_result, ref_alu(ops[n % 10], a_of(n, k), b_of(n, k)));
      tick();
    end
    req_valid = 2'b00;

    // Request withdrawn while in RESP
    rst = 1'b1; tick(); rst = 1'b0; #1;
    set_req(0, ALU_ADD, 32'd20, 32'd22); req_valid = 2'b01; rsp_ready = 2'b00; #1;
    chk("t6_ready", 32'(req_ready), 32'd1);
    tick(); req_valid = 2'b00; #1;
    tick(); set_req(0, ALU_AND, 32'h0000_000F, 32'h0000_0003); req_valid = 2'b01; #1;
    chk("t6_resp_ready", 32'(req_ready), 32'd0);
    chk("t6_resp_valid", 32'(rsp_valid), 32'd1);
    chk("t6_resp_result", rsp_result, 32'd42);
    tick(); req_valid = 2'b00; rsp_ready = 2'b01; #1;
    chk("t6_resp_still", 32'(rsp_valid), 32'd1);
    tick(); #1;
    chk("t6_idle_ready", 32'(req_ready), 32'd0);
    chk("t6_idle_rsp", 32'(rsp_valid), 32'd0);
    chk("t6_keep_op", 32'(alu_op), 32'd2);
    chk("t6_keep_a", alu_a, 32'd20);
    chk("t6_keep_b", alu_b, 32'd22);
    tick(); #1;
    chk("t6_keep_a2", alu_a, 32'd20);
    set_req(1, ALU_OR, 32'd1, 32'd2); req_valid = 2'b11; #1;
    chk("t6_ptr_kept", 32'(req_ready), 32'd2);
    tick(); req_valid = 2'b00; #1;
    chk("t6_new_op", 32'(alu_op), 32'd1);
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Shares the single combinational ALU between `NREQ` requesters, e.g. the core datapath and a load/store address unit. Each requester sends an ALU opcode and two operands over a valid/ready handshake. The block arbitrates round-robin, drives the ALU from registered operands, captures the result and returns it over a per-requester response handshake. One operation is in flight at a time.

## Interface
Parameters:
- `NREQ`, default 2: number of requesters, 2..8.
- `WIDTH`, default 32: operand and result width.

Ports:
- `clk_i`  in  1  clock, rising edge.
- `rst_i`  in  1  synchronous active-high reset.
- `req_valid_i`  in  NREQ  request pending, one bit per requester.
- `req_ready_o`  out  NREQ  request accepted this cycle; at most one bit set.
- `req_aluop_i`  in  NREQ*5  per-requester ALU opcode; requester k occupies bits [5k+4:5k].
- `req_a_i`  in  NREQ*WIDTH  per-requester operand A; same packing.
- `req_b_i`  in  NREQ*WIDTH  per-requester operand B; same packing.
- `rsp_valid_o`  out  NREQ  response valid; one-hot or zero.
- `rsp_ready_i`  in  NREQ  requester takes the response.
- `rsp_result_o`  out  WIDTH  result, shared by all requesters and qualified by `rsp_valid_o`.
- `alu_op_o`  out  5  opcode to the ALU.
- `alu_a_o`  out  WIDTH  operand A to the ALU.
- `alu_b_o`  out  WIDTH  operand B to the ALU.
- `alu_result_i`  in  WIDTH  combinational ALU result.

## Operation
- The FSM has three states: IDLE, EXEC and RESP.
- In IDLE:
  - The round-robin arbiter picks the first requester with `req_valid_i` set, searching upward from `rr_ptr` with wrap-around.
  - It raises `req_ready_o` for that requester only, in the same cycle (combinational from `req_valid_i` and `rr_ptr`).
  - On the handshake, the block latches opcode, A, B and the grant index, then moves to EXEC.
  - `rr_ptr` becomes the granted index + 1, wrapping from `NREQ-1` to 0.
- In EXEC:
  - `alu_*_o` are driven from the latched registers.
  - `alu_result_i` is captured into `result_q` at the clock edge, then the FSM moves to RESP.
- In RESP:
  - `rsp_valid_o[grant]` is held high with `rsp_result_o = result_q` until `rsp_ready_i[grant]`, then the FSM returns to IDLE.
  - `rsp_ready_i` bits of other requesters are ignored.
- Opcodes are passed through unchanged. The block does not decode or reject them.
- `req_ready_o` is 0 in EXEC and RESP, so no new request is accepted while one is in flight.
- If a requester drops `req_valid_i` before `req_ready_o`, no state changes.
- Reset values:
  - state IDLE, `rr_ptr = 0`.
  - `req_ready_o` is combinational, but 0 whenever the block is not in IDLE.
  - `rsp_valid_o = 0`, `rsp_result_o = 0`.
  - `alu_op_o = 0`, `alu_a_o = 0`, `alu_b_o = 0`; latched opcode and operands are cleared.
- Reset in EXEC or RESP discards the operation and no response is issued.
- Outside EXEC, `alu_*_o` hold their last latched values. No glitching to requester inputs.

## Timing
- Cycle 0: request handshake (valid & ready).
- Cycle 1: EXEC; ALU inputs are stable for the whole cycle.
- Cycle 2: `rsp_valid_o` high at the earliest.
- Minimum request-to-response latency is 2 cycles. Throughput is one operation per 3 cycles when `rsp_ready_i` is held high.
- The response is registered. `rsp_valid_o` and `rsp_result_o` are stable until the response handshake completes.
- Request completing on the same edge a response completes: impossible, because requests are only accepted in IDLE.
- A requester may be granted again right after its own response, but only if no other requester is valid.

## Structure
- Shared package `alu_pkg` holds:
  - the 5-bit opcode constants: AND 00000, OR 00001, ADD 00010, SLT 00011, XOR 00100, SLTU 00101, SRL 00110, SLL 00111, SRA 01000, SUB 10010;
  - the FSM state enum (`ARB_IDLE`, `ARB_EXEC`, `ARB_RESP`);
  - the `ALUOP_W = 5` constant.
- One sub-module, `rr_arbiter`: `NREQ`-wide round-robin pick from `req` and `ptr`, producing a one-hot grant and its index. It is purely combinational.

## Test plan
- Reset, then requester 0 sends ADD (00010), A=5, B=7, with `rsp_ready_i` high → `alu_a_o=5` in cycle 1; `rsp_valid_o=01` and `rsp_result_o=12` in cycle 2; back to IDLE in cycle 3.
- After reset, both requesters are valid on the same cycle: req0 SUB 10−3, req1 OR 0xF0|0x0F → req0 is granted first with result 7, then req1 with result 0xFF. No back-to-back grant to req0.
- Backpressure: req1 XOR 0xAA^0xFF with `rsp_ready_i` low for 5 cycles → `rsp_valid_o=10` and result 0x55 held stable for all 5 cycles; req0's `req_ready_o` stays 0 throughout.
- Reset asserted during EXEC of SLL 1<<4 → the next cycle shows state IDLE, all outputs 0 and no response; the following request is served normally.
- Sustained load: both requesters always valid for 20 operations → grants strictly alternate 0,1,0,1…, every result matches a reference ALU model, and `req_ready_o` is never more than one-hot.
- Request withdrawn: req0 raises valid while the block is in RESP, then drops it before IDLE → no grant, no latch update, `rr_ptr` unchanged.
